// File: rtl/sha256_stream_arb_pkg.sv
// Shared types and constants for the SHA-256 stream arbiter.
package sha256_stream_arb_pkg;

  localparam int DEFAULT_DATA_W   = 512;
  localparam int DEFAULT_DIGEST_W = 256;
  localparam int MSG_BLOCKS_W     = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_STREAM,
    ST_WAIT_DIGEST,
    ST_DELIVER
  } arb_state_e;

endpackage

// File: rtl/sha256_rr_arbiter.sv
// Combinational round-robin pick: the first requester at or after rr_ptr wins.
module sha256_rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    rr_ptr,
  output logic [ID_W-1:0]    grant,
  output logic               any_req
);

  int cand;

  // Scan from the farthest candidate back towards rr_ptr so the nearest one is written last.
  always_comb begin
    grant   = rr_ptr;
    cand    = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = (int'(rr_ptr) + k) % NUM_REQ;
      if (req[cand[ID_W-1:0]]) grant = ID_W'(cand);
    end
    any_req = |req;
  end

endmodule

// File: rtl/sha256_stream_arbiter.sv
// Shares one SHA-256 stream engine between NUM_REQ requesters, one whole message
// per grant, and routes the returned digest back to the owner before re-arbitrating.
module sha256_stream_arbiter
  import sha256_stream_arb_pkg::*;
#(
  parameter int NUM_REQ  = 2,
  parameter int DATA_W   = DEFAULT_DATA_W,
  parameter int DIGEST_W = DEFAULT_DIGEST_W,
  parameter int ID_W     = $clog2(NUM_REQ)
) (
  input  logic                      HCLK,
  input  logic                      HRESETn,
  input  logic [NUM_REQ*DATA_W-1:0] req_data_in,
  input  logic [NUM_REQ-1:0]        req_data_in_last,
  input  logic [NUM_REQ-1:0]        req_data_in_valid,
  output logic [NUM_REQ-1:0]        req_data_in_ready,
  output logic [DATA_W-1:0]         eng_data_out,
  output logic                      eng_data_out_last,
  output logic                      eng_data_out_valid,
  input  logic                      eng_data_out_ready,
  input  logic [DIGEST_W-1:0]       eng_digest_in,
  input  logic                      eng_digest_in_valid,
  output logic                      eng_digest_in_ready,
  output logic [DIGEST_W-1:0]       req_digest_out,
  output logic [NUM_REQ-1:0]        req_digest_out_valid,
  input  logic [NUM_REQ-1:0]        req_digest_out_ready,
  output logic                      busy,
  output logic [ID_W-1:0]           owner,
  output logic [MSG_BLOCKS_W-1:0]   msg_blocks
);

  arb_state_e      state;
  arb_state_e      state_nxt;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] grant_idx;
  logic            any_req;
  logic            grant_hs;
  logic            data_hs;
  logic            digest_hs;
  logic            release_hs;

  function automatic logic [MSG_BLOCKS_W-1:0] sat_inc(input logic [MSG_BLOCKS_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [ID_W-1:0] next_ptr(input logic [ID_W-1:0] p);
    return (p == ID_W'(NUM_REQ - 1)) ? '0 : p + 1'b1;
  endfunction

  sha256_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr (
    .req     (req_data_in_valid),
    .rr_ptr  (rr_ptr),
    .grant   (grant_idx),
    .any_req (any_req)
  );

  // Data path is a pure mux of the owner's slice; only valid is gated by the state.
  assign eng_data_out      = req_data_in[owner*DATA_W +: DATA_W];
  assign eng_data_out_last = req_data_in_last[owner];

  assign grant_hs   = (state == ST_IDLE) && any_req;
  assign data_hs    = (state == ST_STREAM) && req_data_in_valid[owner] && eng_data_out_ready;
  assign digest_hs  = (state == ST_WAIT_DIGEST) && eng_digest_in_valid;
  assign release_hs = (state == ST_DELIVER) && req_digest_out_ready[owner];
  assign busy       = (state != ST_IDLE);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt            = state;
    req_data_in_ready    = '0;
    eng_data_out_valid   = 1'b0;
    eng_digest_in_ready  = 1'b0;
    req_digest_out_valid = '0;
    case (state)
      ST_IDLE: begin
        if (any_req) state_nxt = ST_STREAM;
      end
      ST_STREAM: begin
        eng_data_out_valid       = req_data_in_valid[owner];
        req_data_in_ready[owner] = eng_data_out_ready;
        if (data_hs && req_data_in_last[owner]) state_nxt = ST_WAIT_DIGEST;
      end
      ST_WAIT_DIGEST: begin
        eng_digest_in_ready = 1'b1;
        if (eng_digest_in_valid) state_nxt = ST_DELIVER;
      end
      ST_DELIVER: begin
        req_digest_out_valid[owner] = 1'b1;
        if (req_digest_out_ready[owner]) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Owner and block count stay visible after the message so software can inspect the last one.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      owner          <= '0;
      rr_ptr         <= '0;
      msg_blocks     <= '0;
      req_digest_out <= '0;
    end else begin
      if (grant_hs) begin
        owner      <= grant_idx;
        msg_blocks <= '0;
      end
      if (data_hs)    msg_blocks     <= sat_inc(msg_blocks);
      if (digest_hs)  req_digest_out <= eng_digest_in;
      if (release_hs) rr_ptr         <= next_ptr(owner);
    end
  end

endmodule

// File: tb/tb_sha256_stream_arbiter.sv
// Scoreboarded bench for sha256_stream_arbiter with a behavioural engine model.
module tb_sha256_stream_arbiter;

  localparam int NR = 2;
  localparam int DW = 512;
  localparam int GW = 256;

  localparam logic [DW-1:0] ABC_BLK = {32'h61626380, 472'h0, 8'h18};
  localparam logic [GW-1:0] ABC_DIG =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;

  logic            HCLK = 1'b0;
  logic            HRESETn = 1'b0;
  logic [NR*DW-1:0] req_data_in;
  logic [NR-1:0]   req_data_in_last;
  logic [NR-1:0]   req_data_in_valid;
  logic [NR-1:0]   req_data_in_ready;
  logic [DW-1:0]   eng_data_out;
  logic            eng_data_out_last;
  logic            eng_data_out_valid;
  logic            eng_data_out_ready;
  logic [GW-1:0]   eng_digest_in;
  logic            eng_digest_in_valid;
  logic            eng_digest_in_ready;
  logic [GW-1:0]   req_digest_out;
  logic [NR-1:0]   req_digest_out_valid;
  logic [NR-1:0]   req_digest_out_ready = 2'b11;
  logic            busy;
  logic            owner;
  logic [15:0]     msg_blocks;

  logic [DW-1:0] blk0 = '0, blk1 = '0;
  logic          vld0 = 1'b0, vld1 = 1'b0, lst0 = 1'b0, lst1 = 1'b0;

  assign req_data_in       = {blk1, blk0};
  assign req_data_in_valid = {vld1, vld0};
  assign req_data_in_last  = {lst1, lst0};

  always #5 HCLK = ~HCLK;

  sha256_stream_arbiter #(.NUM_REQ(NR)) dut (
    .HCLK                 (HCLK),
    .HRESETn              (HRESETn),
    .req_data_in          (req_data_in),
    .req_data_in_last     (req_data_in_last),
    .req_data_in_valid    (req_data_in_valid),
    .req_data_in_ready    (req_data_in_ready),
    .eng_data_out         (eng_data_out),
    .eng_data_out_last    (eng_data_out_last),
    .eng_data_out_valid   (eng_data_out_valid),
    .eng_data_out_ready   (eng_data_out_ready),
    .eng_digest_in        (eng_digest_in),
    .eng_digest_in_valid  (eng_digest_in_valid),
    .eng_digest_in_ready  (eng_digest_in_ready),
    .req_digest_out       (req_digest_out),
    .req_digest_out_valid (req_digest_out_valid),
    .req_digest_out_ready (req_digest_out_ready),
    .busy                 (busy),
    .owner                (owner),
    .msg_blocks           (msg_blocks)
  );

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [NR-1:0] vld;
    logic          own;
    logic [GW-1:0] dig;
    logic [15:0]   nb;
  } exp_t;
  exp_t exp_q[$];
  exp_t e_cur;

  function automatic logic [DW-1:0] blk_of(input logic [31:0] seed, input int j);
    logic [DW-1:0] b;
    for (int k = 0; k < 16; k++)
      b[k*32 +: 32] = (seed + 32'(j) * 32'd17 + 32'(k)) * 32'h9e3779b1;
    return b;
  endfunction

  function automatic logic [GW-1:0] fold(input logic [GW-1:0] acc, input logic [DW-1:0] b);
    return {acc[GW-2:0], acc[GW-1]} ^ b[GW-1:0] ^ b[DW-1:GW];
  endfunction

  function automatic logic [GW-1:0] exp_digest(input logic [31:0] seed, input int n);
    logic [GW-1:0] acc;
    acc = '0;
    for (int j = 0; j < n; j++) acc = fold(acc, blk_of(seed, j));
    return acc ^ GW'(n);
  endfunction

  function automatic exp_t mk_exp(input int id, input logic [GW-1:0] d, input int n);
    exp_t x;
    x.vld = NR'(1) << id;
    x.own = id[0];
    x.dig = d;
    x.nb  = 16'(n);
    return x;
  endfunction

  // Engine model: folds accepted blocks into a digest and offers it after the last block.
  logic [GW-1:0] e_acc = '0;
  logic [DW-1:0] e_first = '0;
  logic [GW-1:0] dig_val = '0;
  int            e_nblk = 0;
  int            hs_cnt = 0;
  int            bad_ready = 0;
  bit            dig_pending = 0, dig_taken = 0;
  bit            eng_auto = 1, eng_toggle = 0;

  initial forever begin
    @(negedge HCLK);
    if (!HRESETn) begin
      e_acc = '0; e_nblk = 0; dig_pending = 0; dig_taken = 0;
    end else begin
      if (eng_data_out_valid && eng_data_out_ready) begin
        if (e_nblk == 0) e_first = eng_data_out;
        e_acc = fold(e_acc, eng_data_out);
        e_nblk++;
        hs_cnt++;
        if (eng_data_out_last) begin
          dig_val = (e_nblk == 1 && e_first == ABC_BLK) ? ABC_DIG : (e_acc ^ GW'(e_nblk));
          dig_pending = 1; e_acc = '0; e_nblk = 0;
        end
      end
      if (eng_digest_in_valid && eng_digest_in_ready) dig_taken = 1;
      if ((req_data_in_ready & ~(NR'(1) << owner)) != 0 ||
          (req_data_in_ready != 0 && !eng_data_out_ready)) bad_ready++;
    end
  end

  initial begin
    eng_data_out_ready = 1'b1; eng_digest_in_valid = 1'b0; eng_digest_in = '0;
    forever begin
      @(posedge HCLK); #1;
      eng_data_out_ready = eng_toggle ? ~eng_data_out_ready : 1'b1;
      if (!HRESETn) eng_digest_in_valid = 1'b0;
      else begin
        if (dig_taken) begin eng_digest_in_valid = 1'b0; dig_taken = 0; end
        if (eng_auto && dig_pending) begin
          eng_digest_in = dig_val; eng_digest_in_valid = 1'b1; dig_pending = 0;
        end
      end
    end
  end

  // Delivery monitor: pops the scoreboard on the first cycle of each digest delivery.
  bit in_dlv = 0;
  initial forever begin
    @(negedge HCLK);
    if (req_digest_out_valid == '0) in_dlv = 0;
    else if (!in_dlv) begin
      in_dlv = 1;
      n_checks++;
      if (exp_q.size() == 0)
        $display("FAIL dlv_unexpected valid=%b owner=%0d, none expected", req_digest_out_valid, owner);
      else begin
        n_pass++;
        e_cur = exp_q.pop_front();
        n_checks++;
        if ({req_digest_out_valid, owner} !== {e_cur.vld, e_cur.own})
          $display("FAIL dlv_route valid=%b owner=%0d, expected valid=%b owner=%0d",
                   req_digest_out_valid, owner, e_cur.vld, e_cur.own);
        else n_pass++;
        n_checks++;
        if (req_digest_out !== e_cur.dig)
          $display("FAIL dlv_digest got=%h expected=%h", req_digest_out, e_cur.dig);
        else n_pass++;
        n_checks++;
        if (msg_blocks !== e_cur.nb)
          $display("FAIL dlv_msg_blocks got=%0d expected=%0d", msg_blocks, e_cur.nb);
        else n_pass++;
      end
    end
  end

  task automatic drive(input int id, input logic [DW-1:0] b, input logic l, input logic v);
    if (id == 0) begin blk0 = b; lst0 = l; vld0 = v; end
    else         begin blk1 = b; lst1 = l; vld1 = v; end
  endtask

  task automatic send_msgs(input int id, input int nmsg, input int nblk,
                           input logic [31:0] seed, input bit abc);
    @(posedge HCLK); #1;
    for (int m = 0; m < nmsg; m++) begin
      for (int j = 0; j < nblk; j++) begin
        int t = 0;
        drive(id, abc ? ABC_BLK : blk_of(seed + 32'(m) * 32'd1000, j), j == nblk - 1, 1'b1);
        do begin @(negedge HCLK); t++; end while (!req_data_in_ready[id] && t < 2000);
        if (!req_data_in_ready[id]) begin
          n_checks++;
          $display("FAIL send_timeout req=%0d ready=%b, expected ready within 2000 cycles",
                   id, req_data_in_ready);
        end
        @(posedge HCLK); #1;
      end
    end
    drive(id, '0, 1'b0, 1'b0);
  endtask

  task automatic wait_quiet(input string tag);
    int t = 0;
    while ((exp_q.size() != 0 || busy) && t < 3000) begin @(negedge HCLK); t++; end
    if (exp_q.size() != 0 || busy) begin
      n_checks++;
      $display("FAIL %s_timeout pending=%0d busy=%b, expected 0 and 0", tag, exp_q.size(), busy);
    end
    @(posedge HCLK); #1;
  endtask

  task automatic apply_reset();
    HRESETn = 1'b0; vld0 = 1'b0; vld1 = 1'b0;
    repeat (2) @(posedge HCLK);
    #1 HRESETn = 1'b1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge HCLK);
    #1;
    n_checks++;
    if ({busy, owner, msg_blocks} !== 18'h0)
      $display("FAIL rst_ctrl busy=%b owner=%0d blocks=%0d, expected all 0", busy, owner, msg_blocks);
    else n_pass++;
    n_checks++;
    if (req_digest_out !== '0) $display("FAIL rst_digest got=%h expected 0", req_digest_out);
    else n_pass++;
    n_checks++;
    if ({req_data_in_ready, eng_data_out_valid, eng_digest_in_ready, req_digest_out_valid} !== 6'h0)
      $display("FAIL rst_handshake rdy=%b ev=%b dr=%b dv=%b, expected all 0", req_data_in_ready,
               eng_data_out_valid, eng_digest_in_ready, req_digest_out_valid);
    else n_pass++;
    HRESETn = 1'b1;
    // Requester 1 starts a 5-block message; reset hits while its third block is presented.
    @(posedge HCLK); #1;
    for (int j = 0; j < 3; j++) begin
      int t = 0;
      drive(1, blk_of(32'h5000, j), 1'b0, 1'b1);
      if (j == 2) break;
      do begin @(negedge HCLK); t++; end while (!req_data_in_ready[1] && t < 100);
      @(posedge HCLK); #1;
    end
    n_checks++;
    if ({busy, owner, msg_blocks} !== {1'b1, 1'b1, 16'd2})
      $display("FAIL pre_rst busy=%b owner=%0d blocks=%0d, expected 1 1 2", busy, owner, msg_blocks);
    else n_pass++;
    #2 HRESETn = 1'b0;
    #1;
    n_checks++;
    if ({busy, owner, msg_blocks} !== 18'h0)
      $display("FAIL mid_rst_ctrl busy=%b owner=%0d blocks=%0d, expected all 0", busy, owner, msg_blocks);
    else n_pass++;
    n_checks++;
    if ({req_data_in_ready, eng_data_out_valid, req_digest_out_valid} !== 5'h0)
      $display("FAIL mid_rst_handshake rdy=%b ev=%b dv=%b, expected all 0",
               req_data_in_ready, eng_data_out_valid, req_digest_out_valid);
    else n_pass++;
    drive(1, '0, 1'b0, 1'b0);
    repeat (2) @(posedge HCLK);
    #1 HRESETn = 1'b1;
  endtask

  task automatic test_single();
    exp_q.push_back(mk_exp(0, ABC_DIG, 1));
    send_msgs(0, 1, 1, 32'h0, 1'b1);
    wait_quiet("single");
  endtask

  task automatic test_contention();
    apply_reset();
    exp_q.push_back(mk_exp(0, exp_digest(32'h100, 2), 2));
    exp_q.push_back(mk_exp(1, exp_digest(32'h200, 1), 1));
    fork
      send_msgs(0, 1, 2, 32'h100, 1'b0);
      send_msgs(1, 1, 1, 32'h200, 1'b0);
      begin
        @(posedge HCLK);
        @(negedge HCLK);
        n_checks++;
        if ({req_data_in_ready, busy} !== 3'b000)
          $display("FAIL idle_no_ready rdy=%b busy=%b, expected 00 0", req_data_in_ready, busy);
        else n_pass++;
      end
    join
    wait_quiet("contention");
  endtask

  task automatic test_fairness();
    exp_q.push_back(mk_exp(0, exp_digest(32'h300, 1), 1));
    exp_q.push_back(mk_exp(1, exp_digest(32'h400, 3), 3));
    exp_q.push_back(mk_exp(0, exp_digest(32'h300 + 32'd1000, 1), 1));
    exp_q.push_back(mk_exp(1, exp_digest(32'h400 + 32'd1000, 3), 3));
    fork
      send_msgs(0, 2, 1, 32'h300, 1'b0);
      send_msgs(1, 2, 3, 32'h400, 1'b0);
    join
    wait_quiet("fairness");
  endtask

  task automatic test_backpressure();
    int h = hs_cnt;
    int b = bad_ready;
    eng_toggle = 1;
    exp_q.push_back(mk_exp(0, exp_digest(32'h600, 4), 4));
    send_msgs(0, 1, 4, 32'h600, 1'b0);
    wait_quiet("backpressure");
    eng_toggle = 0;
    n_checks++;
    if (hs_cnt - h !== 4) $display("FAIL bp_handshakes got=%0d expected=4", hs_cnt - h);
    else n_pass++;
    n_checks++;
    if (bad_ready !== b) $display("FAIL bp_foreign_ready got=%0d expected=0", bad_ready - b);
    else n_pass++;
    n_checks++;
    if (msg_blocks !== 16'd4) $display("FAIL bp_msg_blocks_kept got=%0d expected=4", msg_blocks);
    else n_pass++;
  endtask

  task automatic test_digest_hold();
    req_digest_out_ready = 2'b10;
    exp_q.push_back(mk_exp(0, exp_digest(32'h700, 1), 1));
    exp_q.push_back(mk_exp(1, exp_digest(32'h800, 2), 2));
    fork
      send_msgs(0, 1, 1, 32'h700, 1'b0);
      begin repeat (3) @(posedge HCLK); send_msgs(1, 1, 2, 32'h800, 1'b0); end
      begin
        int t = 0;
        do begin @(negedge HCLK); t++; end while (!req_digest_out_valid[0] && t < 200);
        for (int c = 0; c < 5; c++) begin
          @(negedge HCLK);
          n_checks++;
          if ({req_digest_out_valid, eng_data_out_valid, busy, owner} !== 5'b01_0_1_0)
            $display("FAIL hold_c%0d dv=%b ev=%b busy=%b owner=%0d, expected 01 0 1 0",
                     c, req_digest_out_valid, eng_data_out_valid, busy, owner);
          else n_pass++;
        end
        @(posedge HCLK); #1;
        req_digest_out_ready = 2'b11;
      end
    join
    wait_quiet("hold");
  endtask

  task automatic test_early_digest();
    logic [GW-1:0] d = {8{32'hdeadbeef}};
    bit last_done = 0;
    bit rdy_seen = 0;
    int gap = 0;
    eng_auto = 0;
    eng_digest_in = d;
    eng_digest_in_valid = 1'b1;
    exp_q.push_back(mk_exp(0, d, 3));
    fork
      send_msgs(0, 1, 3, 32'h900, 1'b0);
      begin
        for (int t = 0; t < 500; t++) begin
          @(negedge HCLK);
          if (last_done) gap++;
          if (eng_digest_in_ready) begin rdy_seen = 1; break; end
          if (eng_data_out_valid && eng_data_out_ready && eng_data_out_last) last_done = 1;
        end
        n_checks++;
        if ({rdy_seen, last_done} !== 2'b11)
          $display("FAIL early_ready seen=%b after_last=%b, expected 1 1", rdy_seen, last_done);
        else n_pass++;
        n_checks++;
        if (gap !== 1) $display("FAIL early_gap got=%0d expected=1", gap);
        else n_pass++;
      end
    join
    wait_quiet("early");
    dig_pending = 0;
    eng_auto = 1;
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog time limit reached, expected completion");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_fairness();
    test_backpressure();
    test_digest_hold();
    test_early_digest();
    n_checks++;
    if (exp_q.size() !== 0) $display("FAIL sb_leftover got=%0d expected=0", exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
